// File: rtl/alu_word_sequencer_pkg.sv
// Shared constants, opcode classes, FSM state encoding and slice ordering for alu_word_sequencer.
package alu_seq_pkg;

    localparam int BUS_WIDTH    = 8;
    localparam int WORDS        = 4;
    localparam int WORD_BITS    = 2;
    localparam int PREFIX_WIDTH = 2;
    localparam int INST_WIDTH   = 3;
    localparam int OPC_WIDTH    = PREFIX_WIDTH + INST_WIDTH;
    localparam int DATA_WIDTH   = BUS_WIDTH * WORDS;

    typedef logic [PREFIX_WIDTH-1:0] class_t;
    typedef logic [WORD_BITS-1:0]    slice_t;

    localparam class_t CLASS_BITWISE = class_t'(0);
    localparam class_t CLASS_SHIFT   = class_t'(1);
    localparam class_t CLASS_ARITH   = class_t'(2);
    localparam class_t CLASS_ILLEGAL = class_t'(3);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } seq_state_t;

    // Right shifts must walk from the top slice down so the shifted-out bit feeds the next lower slice.
    function automatic slice_t slice_index(class_t cls, logic dir_right, slice_t step);
        if ((cls == CLASS_SHIFT) && dir_right) begin
            return slice_t'(WORDS - 1) - step;
        end
        return step;
    endfunction

endpackage

// File: rtl/alu_word_sequencer_if.sv
// Command, ALU slice and response bundle of alu_word_sequencer; rsp_err exists only with ALU_SEQ_ILLEGAL_TRAP_EN.
interface alu_word_sequencer_if
    import alu_seq_pkg::*;
();

    logic                  cmd_valid;
    logic                  cmd_ready;
    logic [OPC_WIDTH-1:0]  cmd_opcode;
    logic [DATA_WIDTH-1:0] cmd_a;
    logic [DATA_WIDTH-1:0] cmd_b;
    logic                  cmd_cin;

    logic [OPC_WIDTH-1:0]  alu_opcode;
    logic [BUS_WIDTH-1:0]  alu_a;
    logic [BUS_WIDTH-1:0]  alu_b;
    logic                  alu_cin;
    logic [BUS_WIDTH-1:0]  alu_y;
    logic                  alu_cout;
    logic                  alu_zero;

    logic                  rsp_valid;
    logic                  rsp_ready;
    logic [DATA_WIDTH-1:0] rsp_y;
    logic                  rsp_cout;
    logic                  rsp_zero;
    logic                  rsp_negative;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic                  rsp_err;
`endif

    modport master (
        input  cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin,
        output cmd_ready,
        output alu_opcode, alu_a, alu_b, alu_cin,
        input  alu_y, alu_cout, alu_zero,
        output rsp_valid, rsp_y, rsp_cout, rsp_zero, rsp_negative,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        output rsp_err,
`endif
        input  rsp_ready
    );

    modport slave (
        output cmd_valid, cmd_opcode, cmd_a, cmd_b, cmd_cin,
        input  cmd_ready,
        input  alu_opcode, alu_a, alu_b, alu_cin,
        output alu_y, alu_cout, alu_zero,
        input  rsp_valid, rsp_y, rsp_cout, rsp_zero, rsp_negative,
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        input  rsp_err,
`endif
        output rsp_ready
    );

endinterface

// File: rtl/alu_word_sequencer.sv
// Runs one wide command through a narrow ALU slice by slice, chaining carry and collecting flags.
// Optional: ALU_SEQ_ILLEGAL_TRAP_EN returns class-3 commands at once with rsp_err set.
//
// state | meaning
// IDLE  | cmd_ready high, waiting for a command
// EXEC  | one slice per cycle while slices remain, then one wrap-up cycle committing flags
// RESP  | rsp_valid high, result held until rsp_ready
module alu_word_sequencer
    import alu_seq_pkg::*;
(
    input logic                  clk,
    input logic                  rst_n,
    alu_word_sequencer_if.master bus
);

    localparam int CNT_W = WORD_BITS + 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(WORDS);

    seq_state_t            state_q;
    seq_state_t            state_d;
    logic [OPC_WIDTH-1:0]  opc_q;
    logic [DATA_WIDTH-1:0] a_q;
    logic [DATA_WIDTH-1:0] b_q;
    logic [DATA_WIDTH-1:0] y_q;
    logic [CNT_W-1:0]      remain_q;
    logic                  carry_q;
    logic                  zero_acc_q;
    logic                  cout_q;
    logic                  zero_q;
    logic                  trap_q;

    class_t cls;
    slice_t step;
    slice_t slice_idx;
    logic   no_carry;
    logic   accept;
    logic   slice_active;
    logic   wrap_up;

    assign cls       = class_t'(opc_q[OPC_WIDTH-1 -: PREFIX_WIDTH]);
    assign no_carry  = (cls == CLASS_BITWISE) || (cls == CLASS_ILLEGAL);
    assign step      = slice_t'(CNT_LOAD - remain_q);
    assign slice_idx = slice_index(cls, opc_q[0], step);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        accept         = 1'b0;
        slice_active   = 1'b0;
        wrap_up        = 1'b0;
        bus.cmd_ready  = 1'b0;
        bus.rsp_valid  = 1'b0;
        bus.alu_opcode = '0;
        bus.alu_a      = '0;
        bus.alu_b      = '0;
        bus.alu_cin    = 1'b0;
        case (state_q)
            IDLE: begin
                bus.cmd_ready = 1'b1;
                if (bus.cmd_valid) begin
                    accept  = 1'b1;
                    state_d = EXEC;
                end
            end
            EXEC: begin
                if (trap_q || (remain_q == '0)) begin
                    wrap_up = 1'b1;
                    state_d = RESP;
                end else begin
                    slice_active   = 1'b1;
                    bus.alu_opcode = opc_q;
                    bus.alu_a      = a_q[slice_idx*BUS_WIDTH +: BUS_WIDTH];
                    bus.alu_b      = b_q[slice_idx*BUS_WIDTH +: BUS_WIDTH];
                    bus.alu_cin    = no_carry ? 1'b0 : carry_q;
                end
            end
            RESP: begin
                bus.rsp_valid = 1'b1;
                if (bus.rsp_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            opc_q      <= '0;
            a_q        <= '0;
            b_q        <= '0;
            y_q        <= '0;
            remain_q   <= '0;
            carry_q    <= 1'b0;
            zero_acc_q <= 1'b0;
            cout_q     <= 1'b0;
            zero_q     <= 1'b0;
        end else begin
            if (accept) begin
                opc_q      <= bus.cmd_opcode;
                a_q        <= bus.cmd_a;
                b_q        <= bus.cmd_b;
                carry_q    <= bus.cmd_cin;
                remain_q   <= CNT_LOAD;
                zero_acc_q <= 1'b1;
                y_q        <= '0;
            end
            if (slice_active) begin
                y_q[slice_idx*BUS_WIDTH +: BUS_WIDTH] <= bus.alu_y;
                zero_acc_q <= zero_acc_q & bus.alu_zero;
                carry_q    <= bus.alu_cout;
                remain_q   <= remain_q - CNT_W'(1);
            end
            // A skipped or carry-less class still reports a clean carry.
            if (wrap_up) begin
                cout_q <= no_carry ? 1'b0 : carry_q;
                zero_q <= zero_acc_q;
            end
        end
    end

`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
    logic err_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            trap_q <= 1'b0;
            err_q  <= 1'b0;
        end else begin
            if (accept) begin
                trap_q <= (class_t'(bus.cmd_opcode[OPC_WIDTH-1 -: PREFIX_WIDTH]) == CLASS_ILLEGAL);
            end
            if (wrap_up) begin
                err_q <= trap_q;
            end
        end
    end

    assign bus.rsp_err = err_q;
`else
    assign trap_q = 1'b0;
`endif

    assign bus.rsp_y        = y_q;
    assign bus.rsp_cout     = cout_q;
    assign bus.rsp_zero     = zero_q;
    assign bus.rsp_negative = y_q[DATA_WIDTH-1];

endmodule

// File: tb/tb_alu_word_sequencer.sv
// Bench for alu_word_sequencer: behavioural 8-bit ALU, directed vectors, corner sequences, random commands.
module tb_alu_word_sequencer;
    import alu_seq_pkg::*;

    logic clk;
    logic rst_n;

    alu_word_sequencer_if bus();

    alu_word_sequencer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp;
    int n_err;

    // Narrow ALU; bitwise classes return a junk carry so the sequencer must mask it.
    logic [BUS_WIDTH:0]   alu_sum;
    logic [BUS_WIDTH-1:0] alu_res;
    always_comb begin
        alu_sum      = '0;
        alu_res      = '0;
        bus.alu_cout = 1'b0;
        case (bus.alu_opcode[OPC_WIDTH-1 -: PREFIX_WIDTH])
            2'd0: begin
                case (bus.alu_opcode[1:0])
                    2'd0:    alu_res = bus.alu_a & bus.alu_b;
                    2'd1:    alu_res = bus.alu_a | bus.alu_b;
                    2'd2:    alu_res = bus.alu_a ^ bus.alu_b;
                    default: alu_res = ~bus.alu_a;
                endcase
                bus.alu_cout = |bus.alu_a;
            end
            2'd1: begin
                if (bus.alu_opcode[0]) begin
                    alu_res      = {bus.alu_cin, bus.alu_a[BUS_WIDTH-1:1]};
                    bus.alu_cout = bus.alu_a[0];
                end else begin
                    alu_res      = {bus.alu_a[BUS_WIDTH-2:0], bus.alu_cin};
                    bus.alu_cout = bus.alu_a[BUS_WIDTH-1];
                end
            end
            2'd2: begin
                alu_sum = {1'b0, bus.alu_a} + {1'b0, (bus.alu_opcode[0] ? ~bus.alu_b : bus.alu_b)}
                          + (BUS_WIDTH+1)'(bus.alu_cin);
                alu_res      = alu_sum[BUS_WIDTH-1:0];
                bus.alu_cout = alu_sum[BUS_WIDTH];
            end
            default: ;
        endcase
        bus.alu_y    = alu_res;
        bus.alu_zero = (alu_res == '0);
    end

    function automatic void ref_model(input logic [OPC_WIDTH-1:0] opc, input logic [DATA_WIDTH-1:0] a,
                                      input logic [DATA_WIDTH-1:0] b, input logic cin,
                                      output logic [DATA_WIDTH-1:0] y, output logic cout);
        logic [DATA_WIDTH:0] s;
        y    = '0;
        cout = 1'b0;
        case (opc[OPC_WIDTH-1 -: PREFIX_WIDTH])
            2'd0: begin
                case (opc[1:0])
                    2'd0:    y = a & b;
                    2'd1:    y = a | b;
                    2'd2:    y = a ^ b;
                    default: y = ~a;
                endcase
            end
            2'd1: begin
                if (opc[0]) begin
                    y = {cin, a[DATA_WIDTH-1:1]};  cout = a[0];
                end else begin
                    y = {a[DATA_WIDTH-2:0], cin};  cout = a[DATA_WIDTH-1];
                end
            end
            2'd2: begin
                s    = {1'b0, a} + {1'b0, (opc[0] ? ~b : b)} + (DATA_WIDTH+1)'(cin);
                y    = s[DATA_WIDTH-1:0];
                cout = s[DATA_WIDTH];
            end
            default: ;
        endcase
    endfunction

    function automatic int exp_latency(input logic [OPC_WIDTH-1:0] opc);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        if (opc[OPC_WIDTH-1 -: PREFIX_WIDTH] == 2'd3) return 1;
`endif
        return WORDS + 1;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    logic [BUS_WIDTH-1:0]  a_seq [WORDS];
    logic                  cin_seq [WORDS];
    int                    lat;
    logic [DATA_WIDTH-1:0] r_y;
    logic                  r_cout, r_zero, r_neg, r_err;

    task automatic run_cmd(input logic [OPC_WIDTH-1:0] opc, input logic [DATA_WIDTH-1:0] a,
                           input logic [DATA_WIDTH-1:0] b, input logic cin, input int hold);
        int  edges;
        int  nrec;
        logic got;
        @(negedge clk);
        check("cmd_ready_idle", bus.cmd_ready, 1);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = opc;
        bus.cmd_a      = a;
        bus.cmd_b      = b;
        bus.cmd_cin    = cin;
        @(posedge clk); #1;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = ~opc;
        bus.cmd_a      = ~a;
        bus.cmd_b      = ~b;
        bus.cmd_cin    = ~cin;
        edges = 0; nrec = 0; got = 1'b0;
        while (!got && edges < 40) begin
            @(negedge clk);
            check("cmd_ready_busy", bus.cmd_ready, 0);
            if (nrec < WORDS) begin
                a_seq[nrec]   = bus.alu_a;
                cin_seq[nrec] = bus.alu_cin;
                nrec++;
            end
            @(posedge clk); #1;
            edges++;
            if (bus.rsp_valid) got = 1'b1;
        end
        check("rsp_valid_seen", got, 1);
        lat    = edges;
        r_y    = bus.rsp_y;
        r_cout = bus.rsp_cout;
        r_zero = bus.rsp_zero;
        r_neg  = bus.rsp_negative;
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        r_err  = bus.rsp_err;
`else
        r_err  = 1'b0;
`endif
        for (int k = 0; k < hold; k++) begin
            @(negedge clk);
            check("hold_valid", bus.rsp_valid, 1);
            check("hold_cmd_ready", bus.cmd_ready, 0);
            check("hold_y", bus.rsp_y, r_y);
            check("hold_flags", {bus.rsp_cout, bus.rsp_zero, bus.rsp_negative}, {r_cout, r_zero, r_neg});
        end
        @(negedge clk);
        bus.rsp_ready = 1'b1;
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        check("ready_after_rsp", bus.cmd_ready, 1);
        check("valid_after_rsp", bus.rsp_valid, 0);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_cmd_ready"}, bus.cmd_ready, 1);
        check({tag, "_rsp_valid"}, bus.rsp_valid, 0);
        check({tag, "_rsp_y"}, bus.rsp_y, 0);
        check({tag, "_rsp_flags"}, {bus.rsp_cout, bus.rsp_zero, bus.rsp_negative}, 0);
        check({tag, "_alu_opcode"}, bus.alu_opcode, 0);
        check({tag, "_alu_ab"}, {bus.alu_a, bus.alu_b, bus.alu_cin}, 0);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
        check({tag, "_rsp_err"}, bus.rsp_err, 0);
`endif
    endtask

    typedef struct {
        logic [OPC_WIDTH-1:0]  opc;
        logic [DATA_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0] b;
        logic                  cin;
        logic [DATA_WIDTH-1:0] y;
        logic                  cout;
        logic                  zero;
        logic                  neg;
    } vec_t;

    vec_t vecs [8];

    initial begin : watchdog
        #500000;
        $display("FAIL watchdog: simulation did not finish, n_err=%0d", n_err);
        $fatal(1, "watchdog expired");
    end

    initial begin : main
        logic [OPC_WIDTH-1:0]  opc;
        logic [DATA_WIDTH-1:0] a, b, ey;
        logic                  cin, ecout, eerr;
        int                    first_acc, second_acc;

        n_cmp = 0;
        n_err = 0;
        vecs[0] = '{5'b10_000, 32'h0000_00FF, 32'h0000_0001, 1'b0, 32'h0000_0100, 1'b0, 1'b0, 1'b0};
        vecs[1] = '{5'b10_000, 32'hFFFF_FFFF, 32'h0000_0001, 1'b0, 32'h0000_0000, 1'b1, 1'b1, 1'b0};
        vecs[2] = '{5'b01_001, 32'h8000_0001, 32'h0000_0000, 1'b0, 32'h4000_0000, 1'b1, 1'b0, 1'b0};
        vecs[3] = '{5'b01_000, 32'h8000_0001, 32'h0000_0000, 1'b1, 32'h0000_0003, 1'b1, 1'b0, 1'b0};
        vecs[4] = '{5'b10_001, 32'h0000_0010, 32'h0000_0020, 1'b1, 32'hFFFF_FFF0, 1'b0, 1'b0, 1'b1};
        vecs[5] = '{5'b00_000, 32'hF0F0_F0F0, 32'hFF00_FF00, 1'b1, 32'hF000_F000, 1'b0, 1'b0, 1'b1};
        vecs[6] = '{5'b00_010, 32'h1234_5678, 32'h1234_5678, 1'b0, 32'h0000_0000, 1'b0, 1'b1, 1'b0};
        vecs[7] = '{5'b11_000, 32'h1234_5678, 32'h9ABC_DEF0, 1'b1, 32'h0000_0000, 1'b0, 1'b1, 1'b0};

        rst_n          = 1'b0;
        bus.cmd_valid  = 1'b0;
        bus.cmd_opcode = '0;
        bus.cmd_a      = '0;
        bus.cmd_b      = '0;
        bus.cmd_cin    = 1'b0;
        bus.rsp_ready  = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_reset_values("reset");
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 8; i++) begin
            run_cmd(vecs[i].opc, vecs[i].a, vecs[i].b, vecs[i].cin, 0);
            check($sformatf("vec%0d_latency", i), lat, exp_latency(vecs[i].opc));
            check($sformatf("vec%0d_y", i), r_y, vecs[i].y);
            check($sformatf("vec%0d_cout", i), r_cout, vecs[i].cout);
            check($sformatf("vec%0d_zero", i), r_zero, vecs[i].zero);
            check($sformatf("vec%0d_neg", i), r_neg, vecs[i].neg);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            check($sformatf("vec%0d_err", i), r_err, (vecs[i].opc[4:3] == 2'd3));
`else
            check($sformatf("vec%0d_err", i), r_err, 0);
`endif
            if (i == 1) begin
                check("ovf_cin_order", {cin_seq[0], cin_seq[1], cin_seq[2], cin_seq[3]}, 4'b0111);
            end
            if (i == 2) begin
                check("shr_a_order", {a_seq[0], a_seq[1], a_seq[2], a_seq[3]}, 32'h8000_0001);
                check("shr_cin_order", {cin_seq[0], cin_seq[1], cin_seq[2], cin_seq[3]}, 4'b0000);
            end
            if (i == 5) begin
                check("and_cin_masked", {cin_seq[0], cin_seq[1], cin_seq[2], cin_seq[3]}, 4'b0000);
            end
        end

        run_cmd(5'b10_000, 32'h0123_4567, 32'h1111_1111, 1'b1, 10);
        check("bp_y", r_y, 32'h1234_5679);
        check("bp_flags", {r_cout, r_zero, r_neg}, 3'b000);

        @(negedge clk);
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 5'b10_000;
        bus.cmd_a      = 32'h1122_3344;
        bus.cmd_b      = 32'h0101_0101;
        bus.cmd_cin    = 1'b0;
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        @(posedge clk);
        @(posedge clk); #1;
        check("mid_exec_alu_a", bus.alu_a, 8'h22);
        rst_n = 1'b0;
        #1;
        check_reset_values("async_reset");
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("no_rsp_after_reset", bus.rsp_valid, 0);
        end
        bus.rsp_ready = 1'b0;

        first_acc  = -1;
        second_acc = -1;
        @(negedge clk);
        bus.rsp_ready  = 1'b1;
        bus.cmd_valid  = 1'b1;
        bus.cmd_opcode = 5'b10_000;
        bus.cmd_a      = 32'h0000_0005;
        bus.cmd_b      = 32'h0000_0003;
        for (int e = 0; e < 30 && second_acc < 0; e++) begin
            if (bus.cmd_ready) begin
                if (first_acc < 0) first_acc = e;
                else second_acc = e;
            end
            if (second_acc < 0) @(negedge clk);
        end
        @(posedge clk); #1;
        bus.cmd_valid = 1'b0;
        check("b2b_interval", second_acc - first_acc, WORDS + 3);
        repeat (12) @(posedge clk);
        #1;
        bus.rsp_ready = 1'b0;
        check("b2b_drained", bus.rsp_valid, 0);

        for (int n = 0; n < 60; n++) begin
            opc = OPC_WIDTH'($urandom_range(0, 31));
            a   = $urandom;
            b   = $urandom;
            cin = 1'($urandom_range(0, 1));
            run_cmd(opc, a, b, cin, $urandom_range(0, 3));
            ref_model(opc, a, b, cin, ey, ecout);
`ifdef ALU_SEQ_ILLEGAL_TRAP_EN
            eerr = (opc[4:3] == 2'd3);
`else
            eerr = 1'b0;
`endif
            check($sformatf("rnd%0d_y op=%0h", n, opc), r_y, ey);
            check($sformatf("rnd%0d_flags op=%0h", n, opc), {r_cout, r_zero, r_neg, r_err},
                  {ecout, (ey == '0), ey[DATA_WIDTH-1], eerr});
            check($sformatf("rnd%0d_latency", n), lat, exp_latency(opc));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
